free_list_mgr: RTL and testbench
================================

FREE_LIST_MGR -- requirements
Module: free_list_mgr

Interface
REQ-001 The block SHALL have parameter NUM_BLOCKS, default 4096, number of cell-memory blocks managed; it must be a power of two.
REQ-002 The block SHALL have parameter ADDR_W, default $clog2(NUM_BLOCKS), block index width.
REQ-003 The block SHALL have port clk, input, 1, the single clock; all logic is on its rising edge.
REQ-004 The block SHALL have port rst, input, 1, synchronous active-high reset.
REQ-005 The block SHALL have port alloc_req, input, 1, a request for one free block index this cycle.
REQ-006 The block SHALL have port alloc_gnt, output, 1, a one-cycle pulse marking alloc_idx valid.
REQ-007 The block SHALL have port alloc_idx, output, ADDR_W, the granted block index.
REQ-008 The block SHALL have port free_req, input, 1, which returns free_idx to the pool this cycle.
REQ-009 The block SHALL have port free_idx, input, ADDR_W, the block index being returned.
REQ-010 The block SHALL have port init_done, output, 1, high once the pool is initialised.
REQ-011 The block SHALL have port free_count, output, ADDR_W+1, the number of free indices, 0..NUM_BLOCKS.
REQ-012 The block SHALL have port err_overflow, output, 1, a sticky flag for an illegal free.

Function
REQ-013 Pool storage SHALL be a circular FIFO of NUM_BLOCKS entries, ADDR_W bits each, with rd_ptr, wr_ptr (ADDR_W, natural wrap) and count (ADDR_W+1).
REQ-014 The FSM SHALL have states INIT and READY; reset enters INIT.
REQ-015 INIT SHALL write entry i = i for i = 0..NUM_BLOCKS-1, one per cycle, then enter READY with rd_ptr=0, wr_ptr=0 and count=NUM_BLOCKS; this takes exactly NUM_BLOCKS cycles.
REQ-016 init_done SHALL be 0 in INIT and 1 in READY.
REQ-017 free_count SHALL equal the registered count: 0 in INIT, count in READY.
REQ-018 Alloc in READY with alloc_req=1 and count>0 SHALL be accepted: read entry[rd_ptr], increment rd_ptr and decrement count.
REQ-019 An accepted alloc SHALL give alloc_gnt=1 with alloc_idx=entry value on the next cycle: fixed 1-cycle latency.
REQ-020 Back-to-back accepted allocs SHALL give consecutive grant pulses, one index per cycle.
REQ-021 alloc_req with count==0, or any alloc_req in INIT, SHALL be ignored: no grant, no state change, no error.
REQ-022 alloc_idx SHALL hold its last value when alloc_gnt=0.
REQ-023 Free in READY with free_req=1 and count<NUM_BLOCKS SHALL be accepted: write free_idx to entry[wr_ptr] and increment wr_ptr.
REQ-024 A same-cycle accepted alloc and accepted free SHALL both proceed, leaving count unchanged.
REQ-025 Acceptance SHALL use the count at the start of the cycle: a free at count==0 does not enable a same-cycle alloc.
REQ-026 free_req at count==NUM_BLOCKS, or free_req in INIT, SHALL be dropped with no state change and SHALL set err_overflow to 1 until reset.
REQ-027 Read and write to the same entry SHALL never occur in one cycle: pointers are equal only at count 0 or NUM_BLOCKS, where alloc or free is rejected.
REQ-028 The order of returned indices SHALL be FIFO: indices are reissued in the order freed.

Reset
REQ-029 rst=1 on any edge SHALL force INIT with the init counter at 0, rd_ptr, wr_ptr and count at 0, and alloc_gnt, alloc_idx, init_done, free_count and err_overflow at 0.
REQ-030 Reset mid-operation SHALL discard all outstanding allocations and rerun the full NUM_BLOCKS-cycle initialisation; a pending grant SHALL NOT appear after reset.

Structure
REQ-031 NUM_BLOCKS, ADDR_W and enum fl_state_t {INIT, READY} SHALL live in mem_pkg.
REQ-032 Storage SHALL be a sub-module fl_ram: 1 write port and 1 read port, ADDR_W-wide data, NUM_BLOCKS deep, registered read with 1-cycle latency, no reset on the array.
REQ-033 FSM, pointers, count and error flag SHALL be in free_list_mgr.

Verification
REQ-034 Scenario: default parameters, release rst, no requests -> init_done rises exactly 4096 cycles later; free_count=4096; err_overflow=0.
REQ-035 Scenario: NUM_BLOCKS=8, after init, alloc_req held 10 cycles -> grants on cycles 1..8 with idx 0..7; no grant on cycles 9–10; free_count=0.
REQ-036 Scenario: NUM_BLOCKS=8, pool empty, free 5 then free 2, then alloc twice -> alloc_idx 5 then 2; free_count returns to 0.
REQ-037 Scenario: NUM_BLOCKS=8, count=3, simultaneous alloc_req and free_req(idx 6) for 4 cycles -> 4 grants; free_count stays 3; later allocs return the freed 6 entries in FIFO order.
REQ-038 Scenario: after init, free_req(idx 1) -> dropped; err_overflow=1 and stays high; free_count=NUM_BLOCKS.
REQ-039 Scenario: NUM_BLOCKS=8, alloc 3 blocks, assert rst for 1 cycle coincident with an alloc_req -> no grant follows; init_done=0 for 8 cycles; then allocs return 0,1,2 again.

Source files
------------

// File: rtl/mem_pkg.sv
// mem_pkg: shared sizing and FSM state type for the cell-memory free list
package mem_pkg;
  localparam int NUM_BLOCKS = 4096;
  localparam int ADDR_W = $clog2(NUM_BLOCKS);
  typedef enum logic {INIT, READY} fl_state_t;
endpackage

// File: rtl/fl_ram.sv
// fl_ram: 1W/1R storage with registered read; the array is never reset
module fl_ram #(
  parameter int DEPTH = 4096,
  parameter int W = 12,
  parameter int AW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);
  logic [W-1:0] mem [DEPTH];
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end
endmodule

// File: rtl/free_list_mgr.sv
// free_list_mgr: FIFO pool of free block indices with self-initialisation
module free_list_mgr #(
  parameter int NUM_BLOCKS = mem_pkg::NUM_BLOCKS,
  parameter int ADDR_W = $clog2(NUM_BLOCKS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              alloc_req,
  output logic              alloc_gnt,
  output logic [ADDR_W-1:0] alloc_idx,
  input  logic              free_req,
  input  logic [ADDR_W-1:0] free_idx,
  output logic              init_done,
  output logic [ADDR_W:0]   free_count,
  output logic              err_overflow
);
  import mem_pkg::*;
  localparam logic [ADDR_W:0] FULL = (ADDR_W+1)'(NUM_BLOCKS);
  fl_state_t state;
  logic [ADDR_W-1:0] init_cnt, rd_ptr, wr_ptr, q, hold;
  logic [ADDR_W:0] count;
  logic ready, take, give;
  assign ready = state == READY;
  assign take = ready && alloc_req && count != '0;
  assign give = ready && free_req && count != FULL;
  assign init_done = ready;
  assign free_count = count;
  // RAM output is only meaningful on a grant; otherwise show the last granted index
  assign alloc_idx = alloc_gnt ? q : hold;
  fl_ram #(.DEPTH(NUM_BLOCKS), .W(ADDR_W)) u_ram (
    .clk,
    .we(!ready || give),
    .waddr(ready ? wr_ptr : init_cnt),
    .wdata(ready ? free_idx : init_cnt),
    .re(take),
    .raddr(rd_ptr),
    .rdata(q)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= INIT;
      init_cnt <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
      count <= '0;
      alloc_gnt <= 1'b0;
      hold <= '0;
      err_overflow <= 1'b0;
    end else begin
      alloc_gnt <= take;
      if (alloc_gnt) hold <= q;
      if (free_req && !give) err_overflow <= 1'b1;
      if (!ready) begin
        init_cnt <= init_cnt + 1'b1;
        if (init_cnt == ADDR_W'(NUM_BLOCKS - 1)) begin
          state <= READY;
          count <= FULL;
        end
      end else begin
        rd_ptr <= rd_ptr + ADDR_W'(take);
        wr_ptr <= wr_ptr + ADDR_W'(give);
        count <= count + (ADDR_W+1)'(give) - (ADDR_W+1)'(take);
      end
    end
  end
endmodule

// File: tb/tb_free_list_mgr.sv
// tb_free_list_mgr: queue-model checks on an 8-entry pool plus default-size init timing
module tb_free_list_mgr;
  localparam int N = 8;
  logic clk = 0;
  logic rst = 1, a = 0, f = 0;
  logic [2:0] fi = 0;
  logic gnt, done, err;
  logic [2:0] idx;
  logic [3:0] cnt;
  logic rst_b = 1, zb = 0;
  logic [11:0] zi = 0;
  logic gnt_b, done_b, err_b;
  logic [11:0] idx_b;
  logic [12:0] cnt_b;
  int tests = 0, fails = 0;
  bit m_ready, m_err, m_gnt;
  int m_init, m_idx;
  int pool[$];

  always #5 clk = ~clk;

  free_list_mgr #(.NUM_BLOCKS(N), .ADDR_W(3)) dut (
    .clk, .rst, .alloc_req(a), .alloc_gnt(gnt), .alloc_idx(idx),
    .free_req(f), .free_idx(fi), .init_done(done), .free_count(cnt), .err_overflow(err)
  );

  free_list_mgr dut_big (
    .clk, .rst(rst_b), .alloc_req(zb), .alloc_gnt(gnt_b), .alloc_idx(idx_b),
    .free_req(zb), .free_idx(zi), .init_done(done_b), .free_count(cnt_b), .err_overflow(err_b)
  );

  task tick(input bit r, input bit ai, input bit fr, input int fv);
    int n;
    bit ga, gf;
    @(negedge clk);
    rst = r; a = ai; f = fr; fi = 3'(fv);
    @(posedge clk);
    if (r) begin
      m_ready = 0; m_init = 0; pool = {}; m_err = 0; m_gnt = 0; m_idx = 0;
    end else if (!m_ready) begin
      m_gnt = 0;
      if (fr) m_err = 1;
      m_init++;
      if (m_init == N) begin
        m_ready = 1;
        for (int i = 0; i < N; i++) pool.push_back(i);
      end
    end else begin
      n = pool.size();
      ga = ai && n > 0;
      gf = fr && n < N;
      if (fr && !gf) m_err = 1;
      m_gnt = ga;
      if (ga) m_idx = pool.pop_front();
      if (gf) pool.push_back(fv & 7);
    end
    #1;
  endtask

  task reset_init();
    tick(1, 0, 0, 0);
    repeat (N) tick(0, 0, 0, 0);
  endtask

  task test_init_default();
    int n;
    rst_b = 1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_b = 0;
    n = 0;
    while (!done_b && n < 5000) begin
      @(posedge clk);
      #1;
      n++;
    end
    tests++; if (n !== 4096) begin fails++; $display("FAIL init_latency_4096: got %0d want 4096", n); end
    tests++; if (cnt_b !== 13'd4096) begin fails++; $display("FAIL big_free_count: got %0d want 4096", cnt_b); end
    tests++; if (err_b !== 1'b0) begin fails++; $display("FAIL big_err: got %0d want 0", err_b); end
  endtask

  task test_reset();
    tick(1, 1, 1, 3);
    tests++; if (gnt !== 1'b0) begin fails++; $display("FAIL reset_gnt: got %0d want 0", gnt); end
    tests++; if (idx !== 3'd0) begin fails++; $display("FAIL reset_idx: got %0d want 0", idx); end
    tests++; if (done !== 1'b0) begin fails++; $display("FAIL reset_done: got %0d want 0", done); end
    tests++; if (cnt !== 4'd0) begin fails++; $display("FAIL reset_count: got %0d want 0", cnt); end
    tests++; if (err !== 1'b0) begin fails++; $display("FAIL reset_err: got %0d want 0", err); end
    for (int i = 1; i <= N; i++) begin
      tick(0, 1, 0, 0);
      tests++; if (done !== (i == N)) begin fails++; $display("FAIL init_done_c%0d: got %0d want %0d", i, done, i == N); end
      tests++; if (gnt !== 1'b0) begin fails++; $display("FAIL init_no_gnt_c%0d: got %0d want 0", i, gnt); end
    end
    tests++; if (cnt !== 4'd8) begin fails++; $display("FAIL init_count: got %0d want 8", cnt); end
  endtask

  task test_overflow();
    tick(0, 0, 1, 1);
    tests++; if (err !== 1'b1) begin fails++; $display("FAIL overflow_set: got %0d want 1", err); end
    tests++; if (cnt !== 4'd8) begin fails++; $display("FAIL overflow_count: got %0d want 8", cnt); end
    repeat (3) tick(0, 1, 0, 0);
    tests++; if (err !== 1'b1) begin fails++; $display("FAIL overflow_sticky: got %0d want 1", err); end
    tests++; if (cnt !== 4'd5) begin fails++; $display("FAIL overflow_after_alloc: got %0d want 5", cnt); end
  endtask

  task test_drain();
    reset_init();
    for (int i = 0; i < 10; i++) begin
      tick(0, 1, 0, 0);
      tests++; if (gnt !== (i < N)) begin fails++; $display("FAIL drain_gnt_c%0d: got %0d want %0d", i + 1, gnt, i < N); end
      if (i < N) begin
        tests++; if (idx !== 3'(i)) begin fails++; $display("FAIL drain_idx_c%0d: got %0d want %0d", i + 1, idx, i); end
      end
    end
    tests++; if (cnt !== 4'd0) begin fails++; $display("FAIL drain_count: got %0d want 0", cnt); end
    tests++; if (idx !== 3'd7) begin fails++; $display("FAIL drain_idx_hold: got %0d want 7", idx); end
  endtask

  task test_free_order();
    tick(0, 1, 1, 5);
    tests++; if (gnt !== 1'b0) begin fails++; $display("FAIL free_at_empty_no_gnt: got %0d want 0", gnt); end
    tick(0, 0, 1, 2);
    tick(0, 1, 0, 0);
    tests++; if (gnt !== 1'b1 || idx !== 3'd5) begin fails++; $display("FAIL order_first: got gnt %0d idx %0d want gnt 1 idx 5", gnt, idx); end
    tick(0, 1, 0, 0);
    tests++; if (gnt !== 1'b1 || idx !== 3'd2) begin fails++; $display("FAIL order_second: got gnt %0d idx %0d want gnt 1 idx 2", gnt, idx); end
    tests++; if (cnt !== 4'd0) begin fails++; $display("FAIL order_count: got %0d want 0", cnt); end
    tests++; if (err !== 1'b0) begin fails++; $display("FAIL order_err: got %0d want 0", err); end
  endtask

  task test_simultaneous();
    int g;
    reset_init();
    repeat (5) tick(0, 1, 0, 0);
    g = 0;
    repeat (4) begin
      tick(0, 1, 1, 6);
      g += gnt;
      tests++; if (idx !== 3'(m_idx)) begin fails++; $display("FAIL simul_idx: got %0d want %0d", idx, m_idx); end
      tests++; if (cnt !== 4'd3) begin fails++; $display("FAIL simul_count: got %0d want 3", cnt); end
    end
    tests++; if (g !== 4) begin fails++; $display("FAIL simul_grants: got %0d want 4", g); end
    repeat (3) begin
      tick(0, 1, 0, 0);
      tests++; if (gnt !== 1'b1 || idx !== 3'(m_idx)) begin fails++; $display("FAIL simul_fifo: got gnt %0d idx %0d want gnt 1 idx %0d", gnt, idx, m_idx); end
    end
    tests++; if (idx !== 3'd6) begin fails++; $display("FAIL simul_last: got %0d want 6", idx); end
  endtask

  task test_reset_mid();
    reset_init();
    repeat (3) tick(0, 1, 0, 0);
    tick(0, 1, 0, 0);
    tick(1, 1, 0, 0);
    tests++; if (gnt !== 1'b0) begin fails++; $display("FAIL mid_reset_gnt: got %0d want 0", gnt); end
    for (int i = 1; i <= N; i++) begin
      tick(0, 0, 0, 0);
      tests++; if (done !== (i == N)) begin fails++; $display("FAIL mid_init_c%0d: got %0d want %0d", i, done, i == N); end
    end
    for (int i = 0; i < 3; i++) begin
      tick(0, 1, 0, 0);
      tests++; if (gnt !== 1'b1 || idx !== 3'(i)) begin fails++; $display("FAIL mid_realloc%0d: got gnt %0d idx %0d want gnt 1 idx %0d", i, gnt, idx, i); end
    end
  endtask

  task test_random();
    for (int c = 0; c < 400; c++) begin
      tick($urandom_range(0, 149) == 0, $urandom_range(0, 1), $urandom_range(0, 2) != 0, $urandom_range(0, 7));
      tests++; if (gnt !== m_gnt) begin fails++; $display("FAIL rnd_gnt_c%0d: got %0d want %0d", c, gnt, m_gnt); end
      tests++; if (idx !== 3'(m_idx)) begin fails++; $display("FAIL rnd_idx_c%0d: got %0d want %0d", c, idx, m_idx); end
      tests++; if (cnt !== 4'(pool.size())) begin fails++; $display("FAIL rnd_count_c%0d: got %0d want %0d", c, cnt, pool.size()); end
      tests++; if (done !== m_ready) begin fails++; $display("FAIL rnd_done_c%0d: got %0d want %0d", c, done, m_ready); end
      tests++; if (err !== m_err) begin fails++; $display("FAIL rnd_err_c%0d: got %0d want %0d", c, err, m_err); end
    end
  endtask

  initial begin
    test_init_default();
    test_reset();
    test_overflow();
    test_drain();
    test_free_order();
    test_simultaneous();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
